// File: rtl/fp_div.sv
// Iterative restoring FP divider (truncating): M+2 cycles per divide, 1 cycle on zero/denormal divisor.
// No backpressure: start is taken only while idle; requests seen while busy are dropped, not queued.
module fp_div #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  flp_a,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  flp_b,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    sign,
    output logic [EXPONENT_WIDTH-1:0]               exponent,
    output logic [MANTISSA_WIDTH-1:0]               quot,
    output logic                                    div_by_zero
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam int W  = EW + MW + 1;
    localparam int CW = $clog2(MW + 2);
    localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW - 1)) - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          sign_r_q, sign_r_d;
    logic [EW-1:0] exp_r_q, exp_r_d;
    logic [MW+1:0] rem_q, rem_d;
    logic [MW:0]   mb_q, mb_d;
    logic [MW:0]   q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          sign_q, sign_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [MW-1:0] quot_q, quot_d;
    logic          dbz_q, dbz_d;

    logic          sgn_a, sgn_b;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          rem_ge;
    logic [MW+1:0] rem_sel;
    logic [MW+1:0] q_next;

    assign sgn_a = flp_a[W-1];
    assign sgn_b = flp_b[W-1];
    assign ea    = flp_a[W-2:MW];
    assign eb    = flp_b[W-2:MW];
    assign fa    = flp_a[MW-1:0];
    assign fb    = flp_b[MW-1:0];

    // One restoring step: remainder stays below 2*mb, so the shift never loses a set bit.
    assign rem_ge  = rem_q >= {1'b0, mb_q};
    assign rem_sel = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign q_next  = {q_q, rem_ge};

    always_comb begin
        state_d  = state_q;
        sign_r_d = sign_r_q;
        exp_r_d  = exp_r_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        sign_d   = sign_q;
        exp_d    = exp_q;
        quot_d   = quot_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_r_d = sgn_a ^ sgn_b;
                    // Exponent is only ever used modulo 2**EW, so only the low bits are kept.
                    exp_r_d  = EW'({2'b00, ea} - {2'b00, eb} + BIAS);
                    if (eb == '0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        exp_d  = '1;
                        quot_d = '0;
                        sign_d = sgn_a ^ sgn_b;
                    end else begin
                        rem_d   = {1'b0, 1'b1, fa};
                        mb_d    = {1'b1, fb};
                        q_d     = '0;
                        cnt_d   = CW'(MW + 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_sel << 1;
                q_d   = q_next[MW:0];
                if (cnt_q == '0) begin
                    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one normalising shift.
                    if (q_next[MW+1]) begin
                        quot_d = q_next[MW:1];
                        exp_d  = exp_r_q;
                    end else begin
                        quot_d = q_next[MW-1:0];
                        exp_d  = exp_r_q - EW'(1);
                    end
                    sign_d  = sign_r_q;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_r_q <= 1'b0;
            exp_r_q  <= '0;
            rem_q    <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            quot_q   <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_r_q <= sign_r_d;
            exp_r_q  <= exp_r_d;
            rem_q    <= rem_d;
            mb_q     <= mb_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            quot_q   <= quot_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = done_q;
    assign sign        = sign_q;
    assign exponent    = exp_q;
    assign quot        = quot_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: vector table through a result scoreboard, plus hand-written multi-cycle sequences.
module tb_fp_div;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] q;
        logic        dbz;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] flp_a;
    logic [31:0] flp_b;
    logic        busy;
    logic        done;
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] quot;
    logic        div_by_zero;

    int   total;
    int   bad;
    res_t sb[$];
    logic prev_done;

    fp_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flp_a       (flp_a),
        .flp_b       (flp_b),
        .busy        (busy),
        .done        (done),
        .sign        (sign),
        .exponent    (exponent),
        .quot        (quot),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done <= 1'b0;
        end else begin
            if (done) begin
                chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
                end else begin
                    res_t r;
                    r = sb.pop_front();
                    chk("sign", {31'b0, sign}, {31'b0, r.s});
                    chk("exponent", {24'b0, exponent}, {24'b0, r.e});
                    chk("quot", {9'b0, quot}, {9'b0, r.q});
                    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, r.dbz});
                end
            end
            prev_done <= done;
        end
    end

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input vec_t v, input int lat);
        int   n;
        logic bsy;
        @(negedge clk);
        flp_a = v.a;
        flp_b = v.b;
        start = 1'b1;
        sb.push_back(v.r);
        @(negedge clk);
        start = 1'b0;
        bsy   = busy;
        n     = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            bsy |= busy;
        end
        chk("latency", n, lat);
        chk("busy_seen", {31'b0, bsy}, {31'b0, (lat != 0)});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_sign"}, {31'b0, sign}, 32'd0);
        chk({tag, "_exponent"}, {24'b0, exponent}, 32'd0);
        chk({tag, "_quot"}, {9'b0, quot}, 32'd0);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int   n;
        int   gap;
        vec_t v;

        vecs[0]  = '{32'h40C00000, 32'h40000000, '{1'b0, 8'h80, 23'h400000, 1'b0}}; // 6/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, '{1'b0, 8'h7D, 23'h2AAAAA, 1'b0}}; // 1/3
        vecs[2]  = '{32'hC0F00000, 32'h40200000, '{1'b1, 8'h80, 23'h400000, 1'b0}}; // -7.5/2.5
        vecs[3]  = '{32'h3F800000, 32'h3F800000, '{1'b0, 8'h7F, 23'h000000, 1'b0}}; // 1/1
        vecs[4]  = '{32'h40A00000, 32'h00000000, '{1'b0, 8'hFF, 23'h000000, 1'b1}}; // 5/0
        vecs[5]  = '{32'h3F800000, 32'hC0000000, '{1'b1, 8'h7E, 23'h000000, 1'b0}}; // 1/-2
        vecs[6]  = '{32'h40000000, 32'h40400000, '{1'b0, 8'h7E, 23'h2AAAAA, 1'b0}}; // 2/3
        vecs[7]  = '{32'h3F800000, 32'h80000000, '{1'b1, 8'hFF, 23'h000000, 1'b1}}; // 1/-0
        vecs[8]  = '{32'h3F800000, 32'h00400000, '{1'b0, 8'hFF, 23'h000000, 1'b1}}; // denormal divisor
        vecs[9]  = '{32'h7F000000, 32'h00800000, '{1'b0, 8'h7C, 23'h000000, 1'b0}}; // exp overflow wraps
        vecs[10] = '{32'h00800000, 32'h7F000000, '{1'b0, 8'h82, 23'h000000, 1'b0}}; // exp underflow wraps
        vecs[11] = '{32'h00000000, 32'h40400000, '{1'b0, 8'hFE, 23'h2AAAAA, 1'b0}}; // dividend exp 0
        vecs[12] = '{32'h3FFFFFFF, 32'h3F800000, '{1'b0, 8'h7F, 23'h7FFFFF, 1'b0}}; // full mantissa
        vecs[13] = '{32'h3F800000, 32'h3FFFFFFF, '{1'b0, 8'h7E, 23'h000000, 1'b0}}; // truncation

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        flp_a = '0;
        flp_b = '0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run(vecs[i], vecs[i].r.dbz ? 0 : 25);
        end

        // A start arriving mid-divide carries new operands but must be dropped.
        @(negedge clk);
        flp_a = 32'h40C00000;
        flp_b = 32'h40000000;
        start = 1'b1;
        sb.push_back(vecs[0].r);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flp_a = 32'h3F800000;
        flp_b = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, n);
        repeat (40) @(negedge clk);
        chk("hold_quot", {9'b0, quot}, 32'h400000);
        chk("hold_exponent", {24'b0, exponent}, 32'h80);
        chk("hold_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a divide clears outputs and suppresses done.
        run(vecs[2], 25);
        @(negedge clk);
        flp_a = 32'h40C00000;
        flp_b = 32'h40000000;
        start = 1'b1;
        sb.push_back(vecs[0].r);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run(vecs[0], 25);

        // Start held high: back-to-back divides, next start taken the cycle after done.
        @(negedge clk);
        flp_a = 32'h3F800000;
        flp_b = 32'h40400000;
        start = 1'b1;
        sb.push_back(vecs[1].r);
        sb.push_back(vecs[1].r);
        @(negedge clk);
        wait_done(60, n);
        chk("b2b_first_latency", n, 25);
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        chk("b2b_done_gap", gap, 26);
        repeat (40) @(negedge clk);
        chk("b2b_drained", sb.size(), 0);

        v = '{32'h40A00000, 32'h00000000, '{1'b0, 8'hFF, 23'h000000, 1'b1}};
        run(v, 0);
        run(vecs[1], 25);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Sequential IEEE-754-style floating-point divider: quot = flp_a / flp_b.
- It is the inverse-operation companion to the single-cycle multiplier in the CNN datapath, and shares its field layout and truncation convention.
- It uses an iterative restoring mantissa divider that produces one quotient bit per clock.
- It has a start/busy/done handshake so normalisation and scaling stages can issue divides and wait for the result.

Parameters:
- EXPONENT_WIDTH, 8, exponent field width. Bias = 2**(EXPONENT_WIDTH-1)-1.
- MANTISSA_WIDTH, 23, stored fraction width (hidden 1 implied).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- flp_a  input  EXPONENT_WIDTH+MANTISSA_WIDTH+1  dividend {sign, exp, frac}. Sampled with start.
- flp_b  input  EXPONENT_WIDTH+MANTISSA_WIDTH+1  divisor, same layout. Sampled with start.
- busy  output  1  high while a division is in progress (state != IDLE).
- done  output  1  one-cycle pulse. Result outputs are valid from this cycle.
- sign  output  1  result sign.
- exponent  output  EXPONENT_WIDTH  result biased exponent.
- quot  output  MANTISSA_WIDTH  result fraction (hidden bit not included).
- div_by_zero  output  1  set with done when the divisor exponent field == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, sign, exponent, quot and div_by_zero = 0.
  - Internal remainder, quotient and count registers = 0.
  - Reset mid-operation aborts the division. No done is produced.
- States: IDLE, CALC.
- IDLE with start=1:
  - Latch the operands.
  - sign_r = a[MSB] ^ b[MSB].
  - exp_r = ea - eb + bias, computed in EXPONENT_WIDTH+2 bits.
  - If eb==0 (zero or denormal divisor), the next edge does all of the following and state stays IDLE:
    - done=1, div_by_zero=1.
    - exponent = all ones, quot = 0, sign = sign_r.
  - Otherwise:
    - rem = {1,frac_a}, mb = {1,frac_b}.
    - count = MANTISSA_WIDTH+1.
    - Go to CALC, busy=1.
- CALC, each edge (restoring step):
  - If rem >= mb: qbit=1 and rem = (rem-mb)<<1. Otherwise qbit=0 and rem = rem<<1.
  - q = {q, qbit}. q is MANTISSA_WIDTH+2 bits.
  - count decrements.
  - rem is MANTISSA_WIDTH+2 bits wide and never overflows.
- Last CALC edge (count==0): the edge that shifts in the final bit also does the following.
  - If q[MANTISSA_WIDTH+1]==1: quot = q[MANTISSA_WIDTH:1] and exponent = exp_r[EXPONENT_WIDTH-1:0].
  - Otherwise: quot = q[MANTISSA_WIDTH-1:0] and exponent = (exp_r-1)[EXPONENT_WIDTH-1:0].
  - sign = sign_r, done=1, div_by_zero=0, busy=0, state -> IDLE.
- Latency:
  - Start sampled at edge k gives done high after edge k+MANTISSA_WIDTH+2, i.e. 25 cycles for the defaults.
  - Divide-by-zero: done after edge k+1.
- Rounding and range:
  - Truncation only, no rounding.
  - Exponent overflow/underflow wraps modulo 2**EXPONENT_WIDTH.
  - Dividend exponent 0 is not special-cased; the hidden 1 is still assumed.
  - NaN/Inf inputs are not special-cased.
- done is high for exactly one cycle.
- sign, exponent, quot and div_by_zero hold their values until the next done.
- start while busy is ignored; there is no queueing.
- start high in the same cycle as done (state IDLE on the following edge): it is accepted on the next edge where state==IDLE. Back-to-back operation means the new start is sampled the cycle after done.
- Holding start high continuously produces consecutive divisions, each 25 cycles long, with done separated by one idle cycle.

Test Plan:
- 6.0/2.0: flp_a=0x40C00000, flp_b=0x40000000 -> after 25 cycles done=1, sign=0, exponent=0x80, quot=0x400000 (3.0).
- 1.0/3.0: 0x3F800000 / 0x40400000 -> sign=0, exponent=0x7D, quot=0x2AAAAA (truncated 0x3EAAAAAA). Exercises the q MSB=0 normalisation path.
- -7.5/2.5: 0xC0F00000 / 0x40200000 -> sign=1, exponent=0x80, quot=0x400000. 1.0/1.0 -> exponent=0x7F, quot=0.
- 5.0/0.0: 0x40A00000 / 0x00000000 -> one cycle after start: done=1, div_by_zero=1, exponent=0xFF, quot=0. busy never rises.
- Start pulsed again at cycle 10 of a running divide, with new operands -> ignored. Only one done, carrying the first result. Outputs stable until the next start completes.
- rst_n driven low at cycle 12 of a divide -> all outputs 0 immediately (asynchronous). No done after release. A fresh 6.0/2.0 then completes normally in 25 cycles.
